// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle ARM main controller: state encodings,
// datapath select codes and the ALU operation decode helper.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCA_RD1    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_EXT  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Data-processing cmd field to ALU operation; unknown cmds fall back to ADD.
  function automatic logic [1:0] alu_ctrl_decode(input logic alu_op, input logic [3:0] cmd);
    logic [1:0] ctrl;
    ctrl = ALU_ADD;
    if (alu_op) begin
      case (cmd)
        4'b0100: ctrl = ALU_ADD;
        4'b0010: ctrl = ALU_SUB;
        4'b0000: ctrl = ALU_AND;
        4'b1100: ctrl = ALU_ORR;
        default: ctrl = ALU_ADD;
      endcase
    end else begin
      ctrl = ALU_ADD;
    end
    return ctrl;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// Combinational ALU decoder: picks the ALU operation and the flag-write
// strobes, which are only meaningful in the ALU writeback state.
module mc_ctrl_fsm_alu_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  logic       alu_op,
  input  logic [4:0] funct,
  input  state_t     state,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w
);

  logic [1:0] ctrl_s;

  // Operation select and flag-write decode.
  always_comb begin
    ctrl_s = alu_ctrl_decode(alu_op, funct[4:1]);
    flag_w = 2'b00;
    if (state == S_ALUWB) begin
      // Logical ops (AND/ORR) leave C and V untouched.
      flag_w = {funct[0], funct[0] & ~ctrl_s[1]};
    end else begin
      flag_w = 2'b00;
    end
    alu_control = ctrl_s;
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle ARM main controller: Moore FSM sequencing fetch/decode/execute/
// writeback, plus the instruction-field decode feeding condlogic and datapath.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter logic [3:0] PC_IDX = 4'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic [3:0] state
);

  state_t     state_r;
  logic       exec_imm_r;

  logic       irwrite_s;
  logic       nextpc_s;
  logic       regw_s;
  logic       memw_s;
  logic       adrsrc_s;
  logic       alu_op_s;
  logic [1:0] src_a_s;
  logic [1:0] src_b_s;
  logic [1:0] res_src_s;
  logic [1:0] alu_control_s;
  logic [1:0] flag_w_s;

  // Instruction sequencer; exec_imm remembers which EXEC state fed ALUWB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_FETCH;
      exec_imm_r <= 1'b0;
    end else begin
      case (state_r)
        S_FETCH:  state_r <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_MEM:  state_r <= S_MEMADR;
            OP_DP:   state_r <= Funct[5] ? S_EXECI : S_EXECR;
            OP_BR:   state_r <= S_BRANCH;
            default: state_r <= S_FETCH;
          endcase
        end
        S_MEMADR: state_r <= Funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state_r <= S_MEMWB;
        S_MEMWB:  state_r <= S_FETCH;
        S_MEMWR:  state_r <= S_FETCH;
        S_EXECR: begin
          exec_imm_r <= 1'b0;
          state_r    <= S_ALUWB;
        end
        S_EXECI: begin
          exec_imm_r <= 1'b1;
          state_r    <= S_ALUWB;
        end
        S_ALUWB:  state_r <= S_FETCH;
        S_BRANCH: state_r <= S_FETCH;
        default:  state_r <= S_FETCH;
      endcase
    end
  end

  // Moore decode of datapath selects and raw strobes from the current state.
  always_comb begin
    irwrite_s = 1'b0;
    nextpc_s  = 1'b0;
    regw_s    = 1'b0;
    memw_s    = 1'b0;
    adrsrc_s  = 1'b0;
    alu_op_s  = 1'b0;
    src_a_s   = SRCA_RD1;
    src_b_s   = SRCB_RD2;
    res_src_s = RES_ALUOUT;
    case (state_r)
      S_FETCH: begin
        irwrite_s = 1'b1;
        nextpc_s  = 1'b1;
        src_a_s   = SRCA_PC;
        src_b_s   = SRCB_FOUR;
        res_src_s = RES_ALURES;
      end
      S_DECODE: begin
        src_a_s   = SRCA_PC;
        src_b_s   = SRCB_FOUR;
        res_src_s = RES_ALURES;
      end
      S_MEMADR: src_b_s = SRCB_EXT;
      S_MEMRD:  adrsrc_s = 1'b1;
      S_MEMWR: begin
        adrsrc_s = 1'b1;
        memw_s   = 1'b1;
      end
      S_MEMWB: begin
        res_src_s = RES_DATA;
        regw_s    = 1'b1;
      end
      S_EXECR:  alu_op_s = 1'b1;
      S_EXECI: begin
        src_b_s  = SRCB_EXT;
        alu_op_s = 1'b1;
      end
      S_ALUWB: begin
        regw_s   = 1'b1;
        alu_op_s = 1'b1;
        src_b_s  = exec_imm_r ? SRCB_EXT : SRCB_RD2;
      end
      S_BRANCH: begin
        src_a_s   = SRCA_ALUOUT;
        src_b_s   = SRCB_EXT;
        res_src_s = RES_ALURES;
      end
      default: begin
        irwrite_s = 1'b0;
        nextpc_s  = 1'b0;
      end
    endcase
  end

  mc_ctrl_fsm_alu_dec u_alu_dec (
    .alu_op      (alu_op_s),
    .funct       (Funct[4:0]),
    .state       (state_r),
    .alu_control (alu_control_s),
    .flag_w      (flag_w_s)
  );

  // Strobes are gated by reset so an aborted instruction cannot leak a write
  // in the cycle reset falls, before the state flop has visibly settled.
  assign IRWrite    = irwrite_s & reset;
  assign NextPC     = nextpc_s & reset;
  assign RegW       = regw_s & reset;
  assign MemW       = memw_s & reset;
  assign FlagW      = flag_w_s & {2{reset}};
  assign PCS        = reset & ((regw_s & (Rd == PC_IDX)) | (state_r == S_BRANCH));

  assign AdrSrc     = adrsrc_s;
  assign ALUSrcA    = src_a_s;
  assign ALUSrcB    = src_b_s;
  assign ResultSrc  = res_src_s;
  assign ALUControl = alu_control_s;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == OP_MEM, Op == OP_BR};
  assign state      = state_r;

endmodule
